reciprocal_iter: RTL and testbench

RECIPROCAL_ITER -- requirements
Module: reciprocal_iter

---
 rtl/reciprocal_pkg.sv | 54 +++++
 rtl/reciprocal_lzc.sv | 29 ++
 rtl/reciprocal_iter.sv | 228 ++++++++++++++++++++++
 tb/tb_reciprocal_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reciprocal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : reciprocal_pkg                                                |
// | Purpose    : Shared FSM state encoding, seed-constant functions and the    |
// |              default QM.N data type for the iterative reciprocal block.    |
// | Options    : RECIPROCAL_ITER_NEWTON_EN adds the NR1/NR2 refinement states. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package reciprocal_pkg;

  localparam int DEF_M = 12;
  localparam int DEF_N = 12;
  localparam int DEF_W = DEF_M + DEF_N;

  typedef logic signed [DEF_W-1:0] q_default_t;

`ifdef RECIPROCAL_ITER_NEWTON_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NORM = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_NR1  = 3'd4,
    S_NR2  = 3'd5,
    S_FIN  = 3'd6,
    S_DONE = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NORM = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_FIN  = 3'd4,
    S_DONE = 3'd5
  } state_t;
`endif

  // round(x - 0.5) equals floor(x) for the non-half-integer products used
  // here, so the seeds reduce to exact integer divisions.
  function automatic longint k1_const(input int n);
    return (longint'(1466) << n) / 1000;
  endfunction

  function automatic longint k2_const(input int n);
    return (longint'(10012) << n) / 10000;
  endfunction

  function automatic longint nsat_const(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reciprocal_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reciprocal_lzc                                                |
// | Purpose    : Parametrised leading-zero counter. An all-zero input reports  |
// |              W.                                                            |
// | Ports      : din   in  W      value to scan                                |
// |              count out LW     leading zeros, LW = $clog2(W+1)              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reciprocal_lzc #(
  parameter  int W  = 24,
  localparam int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [LW-1:0] count
);

  // Scan from LSB upward; the highest set bit is the last one to overwrite.
  always_comb begin
    count = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        count = LW'(W - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reciprocal_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reciprocal_iter                                               |
// | Purpose    : Multi-cycle signed QM.N reciprocal. The operand magnitude is  |
// |              normalised into [0.5,1), a two-step polynomial seed is built  |
// |              on one shared WxW multiplier, then rescaled, saturated and    |
// |              re-signed.                                                    |
// | Ports      : clk      in  1  rising-edge clock                             |
// |              reset_n  in  1  asynchronous active-low reset                 |
// |              i_valid  in  1  operand valid                                 |
// |              i_ready  out 1  high only in IDLE                             |
// |              i_data   in  W  signed QM.N operand                           |
// |              i_abs    in  1  return magnitude only                         |
// |              o_valid  out 1  result valid (held until o_ready)             |
// |              o_ready  in  1  consumer accepts result                       |
// |              o_data   out W  signed QM.N reciprocal                        |
// |              o_sat    out 1  result saturated                              |
// | Options    : RECIPROCAL_ITER_NEWTON_EN inserts NR1/NR2 (latency 4 -> 6).   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reciprocal_iter #(
  parameter  int M  = 12,
  parameter  int N  = 12,
  localparam int W  = M + N,
  localparam int LW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_abs,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_sat
);

  import reciprocal_pkg::*;

  localparam logic signed [W-1:0] K1   = W'(k1_const(N));
  localparam logic signed [W-1:0] K2   = W'(k2_const(N));
  localparam logic        [W-1:0] NSAT = W'(nsat_const(W));
`ifdef RECIPROCAL_ITER_NEWTON_EN
  localparam logic signed [W-1:0] TWO  = W'(longint'(2) << N);
`endif

  state_t state, state_nxt;

  logic [W-1:0]        data_q;
  logic                abs_q, neg_q, zero_q;
  logic [LW-1:0]       lzc_q;
  logic signed [W-1:0] a_q, b_q, c_q, e_q;
`ifdef RECIPROCAL_ITER_NEWTON_EN
  logic signed [W-1:0] r_q, t_q;
  logic                ovf_q;
`endif

  logic [W-1:0]          mag;
  logic [LW-1:0]         lzc_w;
  logic [W-1:0]          norm_w;
  logic signed [W-1:0]   b_w, d_w;
  logic signed [W-1:0]   mul_x, mul_y, mul_slice;
  logic signed [2*W-1:0] product;
  logic                  unused_prod;
  logic signed [W-1:0]   scaled_e;
  logic                  e_ovf;
  logic [W-1:0]          recip;
  logic                  recip_ovf;
  int                    fin_shift;
  logic [2*W-1:0]        frame;
  logic                  fin_sat;
  logic [W-1:0]          fin_mag, fin_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_nxt = S_NORM;
      end
      S_NORM: state_nxt = S_MUL1;
      S_MUL1: state_nxt = S_MUL2;
`ifdef RECIPROCAL_ITER_NEWTON_EN
      S_MUL2: state_nxt = S_NR1;
      S_NR1:  state_nxt = S_NR2;
      S_NR2:  state_nxt = S_FIN;
`else
      S_MUL2: state_nxt = S_FIN;
`endif
      S_FIN:  state_nxt = S_DONE;
      S_DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- normalisation ----------------
  // The most-negative operand negates to itself; read unsigned it is the
  // correct magnitude 2^(W-1).
  assign mag = data_q[W-1] ? -data_q : data_q;

  reciprocal_lzc #(.W(W)) u_lzc (
    .din   (mag),
    .count (lzc_w)
  );

  // Left-justify, then drop M bits so the leading one lands on bit N-1 (0.5).
  assign norm_w = (mag << lzc_w) >> M;

  // ---------------- shared multiplier ----------------
  assign b_w = K1 - a_q;
  assign d_w = K2 - c_q;

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state)
      S_MUL1: begin mul_x = a_q; mul_y = b_w; end
      S_MUL2: begin mul_x = d_w; mul_y = b_q; end
`ifdef RECIPROCAL_ITER_NEWTON_EN
      S_NR1:  begin mul_x = a_q; mul_y = scaled_e; end
      S_NR2:  begin mul_x = r_q; mul_y = TWO - t_q; end
`endif
      default: ;
    endcase
  end

  assign product     = mul_x * mul_y;
  assign mul_slice   = product[N +: W];
  assign unused_prod = ^{product[N-1:0], product[2*W-1:N+W]};

  // ---------------- finish: x4, rescale, saturate, sign ----------------
  assign scaled_e = {e_q[W-3:0], 2'b00};
  assign e_ovf    = e_q[W-1] | e_q[W-2];

`ifdef RECIPROCAL_ITER_NEWTON_EN
  assign recip     = r_q;
  assign recip_ovf = ovf_q;
`else
  assign recip     = scaled_e;
  assign recip_ovf = e_ovf;
`endif

  always_comb begin
    fin_shift = M - int'(lzc_q);
    frame     = {{W{1'b0}}, recip};
    if (fin_shift >= 0) begin
      frame = frame >> fin_shift;
    end else begin
      frame = frame << (-fin_shift);
    end
    // Magnitude must fit below the sign bit of the result window.
    fin_sat  = recip_ovf | zero_q | (|frame[2*W-1:W-1]);
    fin_mag  = fin_sat ? NSAT : frame[W-1:0];
    fin_data = neg_q ? -fin_mag : fin_mag;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      abs_q  <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      lzc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      e_q    <= '0;
`ifdef RECIPROCAL_ITER_NEWTON_EN
      r_q    <= '0;
      t_q    <= '0;
      ovf_q  <= 1'b0;
`endif
      o_data <= '0;
      o_sat  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            data_q <= i_data;
            abs_q  <= i_abs;
          end
        end
        S_NORM: begin
          a_q    <= norm_w;
          lzc_q  <= lzc_w;
          neg_q  <= data_q[W-1] & ~abs_q;
          zero_q <= (mag == '0);
        end
        S_MUL1: begin
          b_q <= b_w;
          c_q <= mul_slice;
        end
        S_MUL2: e_q <= mul_slice;
`ifdef RECIPROCAL_ITER_NEWTON_EN
        S_NR1: begin
          r_q   <= scaled_e;
          ovf_q <= e_ovf;
          t_q   <= mul_slice;
        end
        S_NR2: r_q <= mul_slice;
`endif
        S_FIN: begin
          o_data <= fin_data;
          o_sat  <= fin_sat;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reciprocal_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_reciprocal_iter                                            |
// | Purpose    : Self-checking bench for reciprocal_iter (Q12.12). Expected    |
// |              results are queued at send time and popped on o_valid.       |
// | Options    : RECIPROCAL_ITER_NEWTON_EN switches to a random error sweep.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_reciprocal_iter;

  localparam int M = 12;
  localparam int N = 12;
  localparam int W = M + N;
`ifdef RECIPROCAL_ITER_NEWTON_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_data = '0;
  logic         i_abs = 1'b0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_data;
  logic         o_sat;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         sat;
    string        tag;
  } exp_t;
  exp_t sb[$];

  reciprocal_iter #(.M(M), .N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_abs   (i_abs),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic s, input string tag);
    exp_t e;
    e.data = d;
    e.sat  = s;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] d, input logic a);
    int guard;
    guard = 0;
    while (!i_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_send", i_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_abs   = a;
    tick();
    i_valid = 1'b0;
    i_data  = '0;
    i_abs   = 1'b0;
    check("busy_after_accept", i_ready, 0);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!o_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    check("scoreboard_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_data"}, o_data, e.data);
      check({e.tag, "_sat"}, o_sat, e.sat);
    end
  endtask

  task automatic handshake();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check("ready_after_handshake", i_ready, 1);
    check("valid_after_handshake", o_valid, 0);
  endtask

  task automatic run_op(input logic [W-1:0] d, input logic a,
                        input logic [W-1:0] ed, input logic es, input string tag);
    int cyc;
    push_exp(ed, es, tag);
    send(d, a);
    wait_result(cyc);
    check({tag, "_latency"}, cyc, LAT);
    compare_pop();
    handshake();
  endtask

  initial begin
    int cyc;

    // Reset state
    repeat (3) tick();
    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_sat", o_sat, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_i_ready", i_ready, 1);

`ifndef RECIPROCAL_ITER_NEWTON_EN
    // Directed results
    run_op(24'h001000, 1'b0, 24'h001002, 1'b0, "one");
    run_op(24'h002000, 1'b0, 24'h000801, 1'b0, "two");
    run_op(24'hFFF000, 1'b0, 24'hFFEFFE, 1'b0, "neg_one");
    run_op(24'hFFF000, 1'b1, 24'h001002, 1'b0, "neg_one_abs");
    run_op(24'h000001, 1'b0, 24'h7FFFFF, 1'b1, "tiny");
    run_op(24'h000000, 1'b0, 24'h7FFFFF, 1'b1, "zero");
    run_op(24'h000800, 1'b0, 24'h002004, 1'b0, "half");
    run_op(24'h003000, 1'b0, 24'h000550, 1'b0, "three");
    run_op(24'hFFD000, 1'b0, 24'hFFFAB0, 1'b0, "neg_three");
    run_op(24'hFFD000, 1'b1, 24'h000550, 1'b0, "neg_three_abs");
    run_op(24'h800000, 1'b0, 24'hFFFFFE, 1'b0, "most_neg");
    run_op(24'h800000, 1'b1, 24'h000002, 1'b0, "most_neg_abs");

    // Back-pressure: result held, busy, extra input ignored
    push_exp(24'h000801, 1'b0, "stall");
    send(24'h002000, 1'b0);
    wait_result(cyc);
    check("stall_latency", cyc, LAT);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", o_valid, 1);
      check("stall_data", o_data, sb[0].data);
      check("stall_sat", o_sat, sb[0].sat);
      check("stall_busy", i_ready, 0);
      if (k == 4) begin
        i_valid = 1'b1;
        i_data  = 24'h000800;
      end else begin
        i_valid = 1'b0;
        i_data  = '0;
      end
      tick();
    end
    i_valid = 1'b0;
    compare_pop();
    handshake();
    for (int k = 0; k < 6; k++) begin
      check("ignored_input_no_result", o_valid, 0);
      tick();
    end

    // Reset during MUL1 aborts the operation
    send(24'h004000, 1'b0);
    tick();
    reset_n = 1'b0;
    #2;
    check("abort_o_valid", o_valid, 0);
    check("abort_i_ready", i_ready, 1);
    check("abort_o_data", o_data, 0);
    check("abort_o_sat", o_sat, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_no_result", o_valid, 0);
    end
    run_op(24'h001000, 1'b0, 24'h001002, 1'b0, "after_abort");
`else
    // Refined build: error against the truncated ideal reciprocal
    for (int k = 0; k < 32; k++) begin
      logic [W-1:0] x;
      longint ideal, diff;
      x = W'($urandom_range(4096, (1 << (W - 1)) - 1));
      ideal = (longint'(1) << (2 * N)) / longint'(x);
      send(x, 1'b0);
      wait_result(cyc);
      check("nr_latency", cyc, LAT);
      diff = longint'(o_data) - ideal;
      check("nr_error_within_2lsb", ((diff <= 2) && (diff >= -2)), 1);
      handshake();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
